// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: unpack/align, add, normalise/round/pack.
// Round-to-nearest-even with full subnormal support; the whole pipe stalls on output backpressure.
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         nan,
  output logic         inexact
);

  localparam int SIG_W = MAN_W + 1;
  localparam int AL_W  = MAN_W + 3;
  localparam int SUM_W = MAN_W + 5;
  localparam int SH_W  = $clog2(AL_W + 1);
  localparam int LZ_W  = $clog2(SUM_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Stage 1: unpack, order by magnitude, align the smaller significand
  logic              a_sgn, b_sgn, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0]  a_exp, b_exp, big_exp, sml_exp, exp_diff;
  logic [SIG_W-1:0]  a_sig, b_sig, big_sig, sml_sig;
  logic [SH_W-1:0]   al_sh;
  logic [2*AL_W-1:0] al_wide;

  always_comb begin
    a_sgn    = a[W-1];
    b_sgn    = b[W-1] ^ sub;
    a_exp    = (a[W-2:MAN_W] == '0) ? EXP_W'(1) : a[W-2:MAN_W];
    b_exp    = (b[W-2:MAN_W] == '0) ? EXP_W'(1) : b[W-2:MAN_W];
    a_sig    = {a[W-2:MAN_W] != '0, a[MAN_W-1:0]};
    b_sig    = {b[W-2:MAN_W] != '0, b[MAN_W-1:0]};
    a_nan    = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] != '0);
    b_nan    = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] != '0);
    a_inf    = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] == '0);
    b_inf    = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] == '0);
    swap     = b[W-2:0] > a[W-2:0];
    big_exp  = swap ? b_exp : a_exp;
    sml_exp  = swap ? a_exp : b_exp;
    big_sig  = swap ? b_sig : a_sig;
    sml_sig  = swap ? a_sig : b_sig;
    exp_diff = big_exp - sml_exp;
    al_sh    = (32'(exp_diff) >= 32'(AL_W)) ? SH_W'(AL_W) : SH_W'(exp_diff);
    // Lower half of the wide shift collects every shifted-out bit for sticky
    al_wide  = {sml_sig, 2'b00, {AL_W{1'b0}}} >> al_sh;
  end

  logic             s1_valid, s1_sign, s1_sub_op, s1_sticky, s1_nan, s1_inf, s1_inf_s;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_big;
  logic [AL_W-1:0]  s1_sml;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sub_op <= 1'b0;
      s1_sticky <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_inf_s  <= 1'b0;
      s1_exp    <= '0;
      s1_big    <= '0;
      s1_sml    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= swap ? b_sgn : a_sgn;
      s1_sub_op <= a_sgn ^ b_sgn;
      s1_sticky <= |al_wide[AL_W-1:0];
      s1_nan    <= a_nan | b_nan | (a_inf & b_inf & (a_sgn ^ b_sgn));
      s1_inf    <= a_inf | b_inf;
      s1_inf_s  <= a_inf ? a_sgn : b_sgn;
      s1_exp    <= big_exp;
      s1_big    <= big_sig;
      s1_sml    <= al_wide[2*AL_W-1:AL_W];
    end
  end

  // Stage 2: magnitude add/subtract; sticky rides as the LSB so borrows are exact
  logic [SUM_W-1:0] big_x, sml_x, sum;
  logic [LZ_W-1:0]  lzc;

  always_comb begin
    big_x = {1'b0, s1_big, 3'b000};
    sml_x = {1'b0, s1_sml, s1_sticky};
    sum   = s1_sub_op ? (big_x - sml_x) : (big_x + sml_x);
    lzc   = LZ_W'(SUM_W - 1);
    for (int unsigned i = 0; i < SUM_W - 1; i++) begin
      if (sum[i]) lzc = LZ_W'(SUM_W - 2 - i);
    end
  end

  logic             s2_valid, s2_sign, s2_sub_op, s2_nan, s2_inf, s2_inf_s;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [LZ_W-1:0]  s2_lzc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sub_op <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_inf_s  <= 1'b0;
      s2_exp    <= '0;
      s2_sum    <= '0;
      s2_lzc    <= '0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_sub_op <= s1_sub_op;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_inf_s  <= s1_inf_s;
      s2_exp    <= s1_exp;
      s2_sum    <= sum;
      s2_lzc    <= lzc;
    end
  end

  // Stage 3: normalise, round to nearest even, pack and apply specials
  logic [SUM_W-2:0] norm;
  logic [EXP_W:0]   exp_n, exp_f;
  logic [31:0]      shl;
  logic [SIG_W:0]   rnd;
  logic             rnd_up, lost, res_sign;
  logic [W-1:0]     res_c;
  logic             ovf_c, zero_c, nan_c, inx_c;

  always_comb begin
    shl = '0;
    if (s2_sum[SUM_W-1]) begin
      norm  = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
      exp_n = {1'b0, s2_exp} + (EXP_W+1)'(1);
    end else begin
      // A clamped shift leaves the hidden bit clear: the value is subnormal
      shl   = (32'(s2_lzc) < (32'(s2_exp) - 32'd1)) ? 32'(s2_lzc) : (32'(s2_exp) - 32'd1);
      norm  = s2_sum[SUM_W-2:0] << shl;
      exp_n = (EXP_W+1)'(32'(s2_exp) - shl);
    end
    lost   = |norm[2:0];
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd    = {1'b0, norm[SUM_W-2:3]} + (SIG_W+1)'(rnd_up);
    if (rnd[SIG_W])      exp_f = exp_n + (EXP_W+1)'(1);
    else if (rnd[MAN_W]) exp_f = exp_n;
    else                 exp_f = '0;
    res_sign = (s2_sub_op && (s2_sum == '0)) ? 1'b0 : s2_sign;

    res_c  = {res_sign, exp_f[EXP_W-1:0], rnd[MAN_W-1:0]};
    ovf_c  = 1'b0;
    zero_c = 1'b0;
    nan_c  = 1'b0;
    inx_c  = 1'b0;
    if (s2_nan) begin
      res_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      nan_c = 1'b1;
    end else if (s2_inf) begin
      res_c = {s2_inf_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (exp_f >= {1'b0, EXP_ONES}) begin
      res_c = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else begin
      zero_c = (res_c[W-2:0] == '0);
      inx_c  = lost;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      nan       <= 1'b0;
      inexact   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      result    <= res_c;
      overflow  <= ovf_c;
      zero      <= zero_c;
      nan       <= nan_c;
      inexact   <= inx_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: FP16 arithmetic, rounding, specials,
// backpressure and reset, plus an FP32 instance.
module tb_fp_add_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic [3:0]  f;   // {overflow, zero, nan, inexact}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic overflow, zero, nan, inexact;
  logic in_valid32, in_ready32, sub32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;
  logic overflow32, zero32, nan32, inexact32;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .zero(zero), .nan(nan), .inexact(inexact)
  );

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .overflow(overflow32), .zero(zero32), .nan(nan32), .inexact(inexact32)
  );

  // Issue one FP16 op, return out_valid one cycle early and at the expected slot
  task automatic run16(input logic [15:0] opa, input logic [15:0] opb, input logic ops,
                       output logic early, output logic valid,
                       output logic [15:0] r, output logic [3:0] f);
    @(negedge clk);
    a = opa; b = opb; sub = ops; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    early = out_valid;
    @(negedge clk);
    valid = out_valid;
    r = result;
    f = {overflow, zero, nan, inexact};
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
    checks++;
    if (result !== 16'h0000) begin fails++; $display("FAIL reset result: got %h required 0000", result); end
    checks++;
    if ({overflow, zero, nan, inexact} !== 4'b0000)
      begin fails++; $display("FAIL reset flags: got %b required 0000", {overflow, zero, nan, inexact}); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid32 !== 1'b0 || result32 !== 32'h0)
      begin fails++; $display("FAIL reset fp32: valid=%b result=%h required 0/00000000", out_valid32, result32); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    vec_t tv [3];
    logic ve, vv; logic [15:0] r; logic [3:0] f;
    tv[0] = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000};
    tv[1] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};
    tv[2] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 4'b0000};
    foreach (tv[i]) begin
      run16(tv[i].a, tv[i].b, tv[i].s, ve, vv, r, f);
      checks++;
      if (ve !== 1'b0 || vv !== 1'b1)
        begin fails++; $display("FAIL add[%0d] latency: early=%b valid=%b required 0/1", i, ve, vv); end
      checks++;
      if (r !== tv[i].r) begin fails++; $display("FAIL add[%0d] result: got %h required %h", i, r, tv[i].r); end
      checks++;
      if (f !== tv[i].f) begin fails++; $display("FAIL add[%0d] flags: got %b required %b", i, f, tv[i].f); end
    end
  endtask

  task automatic test_zero();
    vec_t tv [4];
    logic ve, vv; logic [15:0] r; logic [3:0] f;
    tv[0] = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0100};
    tv[1] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0100};
    tv[2] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0100};
    tv[3] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'b0100};
    foreach (tv[i]) begin
      run16(tv[i].a, tv[i].b, tv[i].s, ve, vv, r, f);
      checks++;
      if (vv !== 1'b1) begin fails++; $display("FAIL zero[%0d] valid: got %b required 1", i, vv); end
      checks++;
      if (r !== tv[i].r) begin fails++; $display("FAIL zero[%0d] result: got %h required %h", i, r, tv[i].r); end
      checks++;
      if (f !== tv[i].f) begin fails++; $display("FAIL zero[%0d] flags: got %b required %b", i, f, tv[i].f); end
    end
  endtask

  task automatic test_round();
    vec_t tv [6];
    logic ve, vv; logic [15:0] r; logic [3:0] f;
    tv[0] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001};
    tv[1] = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001};
    tv[2] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000};
    tv[3] = '{16'h03FF, 16'h0001, 1'b0, 16'h0400, 4'b0000};
    tv[4] = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'b0001};
    tv[5] = '{16'h3C00, 16'h0C00, 1'b1, 16'h3C00, 4'b0001};
    foreach (tv[i]) begin
      run16(tv[i].a, tv[i].b, tv[i].s, ve, vv, r, f);
      checks++;
      if (vv !== 1'b1) begin fails++; $display("FAIL round[%0d] valid: got %b required 1", i, vv); end
      checks++;
      if (r !== tv[i].r) begin fails++; $display("FAIL round[%0d] result: got %h required %h", i, r, tv[i].r); end
      checks++;
      if (f !== tv[i].f) begin fails++; $display("FAIL round[%0d] flags: got %b required %b", i, f, tv[i].f); end
    end
  endtask

  task automatic test_special();
    vec_t tv [7];
    logic ve, vv; logic [15:0] r; logic [3:0] f;
    tv[0] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b1001};
    tv[1] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0010};
    tv[2] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0010};
    tv[3] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000};
    tv[4] = '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 4'b0000};
    tv[5] = '{16'h3C00, 16'h7D00, 1'b0, 16'h7E00, 4'b0010};
    tv[6] = '{16'h7BFF, 16'h3C00, 1'b0, 16'h7BFF, 4'b0001};
    foreach (tv[i]) begin
      run16(tv[i].a, tv[i].b, tv[i].s, ve, vv, r, f);
      checks++;
      if (vv !== 1'b1) begin fails++; $display("FAIL special[%0d] valid: got %b required 1", i, vv); end
      checks++;
      if (r !== tv[i].r) begin fails++; $display("FAIL special[%0d] result: got %h required %h", i, r, tv[i].r); end
      checks++;
      if (f !== tv[i].f) begin fails++; $display("FAIL special[%0d] flags: got %b required %b", i, f, tv[i].f); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vr [4];
    logic [15:0] held;
    int sent, got;
    va = '{16'h3C00, 16'h3C00, 16'h4200, 16'h4400};
    vb = '{16'h4000, 16'h3C00, 16'h4200, 16'h3C00};
    vr = '{16'h4200, 16'h4000, 16'h4600, 16'h4500};
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = (sent < 4);
      if (sent < 4) begin a = va[sent]; b = vb[sent]; sub = 1'b0; end
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
          begin fails++; $display("FAIL stall[%0d]: in_ready=%b out_valid=%b required 0/1", cyc, in_ready, out_valid); end
        checks++;
        if (cyc == 3) begin
          if (result !== vr[0]) begin fails++; $display("FAIL stall head: got %h required %h", result, vr[0]); end
          held = result;
        end else if (result !== held) begin
          fails++; $display("FAIL stall hold[%0d]: got %h required %h", cyc, result, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (result !== vr[got]) begin fails++; $display("FAIL bp_out[%0d]: got %h required %h", got, result, vr[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 4 || sent != 4) begin fails++; $display("FAIL bp_count: got=%0d sent=%0d required 4/4", got, sent); end
  endtask

  task automatic test_reset_midflight();
    int ghosts;
    logic ve, vv; logic [15:0] r; logic [3:0] f;
    @(negedge clk); a = 16'h3C00; b = 16'h4000; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); a = 16'h4000; b = 16'h4000;
    @(negedge clk); a = 16'h4200; b = 16'h4200;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL midflight pre: out_valid=%b required 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000)
      begin fails++; $display("FAIL midflight async: valid=%b result=%h required 0/0000", out_valid, result); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ghosts = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ghosts++;
    end
    checks++;
    if (ghosts != 0) begin fails++; $display("FAIL midflight ghosts: got %0d required 0", ghosts); end
    run16(16'h4400, 16'h4400, 1'b0, ve, vv, r, f);
    checks++;
    if (ve !== 1'b0 || vv !== 1'b1 || r !== 16'h4800)
      begin fails++; $display("FAIL midflight new op: early=%b valid=%b result=%h required 0/1/4800", ve, vv, r); end
  endtask

  task automatic test_fp32();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    logic        vs [3];
    logic [3:0]  vf [3];
    logic        ve;
    va = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF};
    vb = '{32'h40000000, 32'h3F800000, 32'h7F7FFFFF};
    vs = '{1'b0, 1'b1, 1'b0};
    vr = '{32'h40400000, 32'h00000000, 32'h7F800000};
    vf = '{4'b0000, 4'b0100, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a32 = va[i]; b32 = vb[i]; sub32 = vs[i]; in_valid32 = 1'b1;
      @(negedge clk);
      in_valid32 = 1'b0;
      @(negedge clk);
      ve = out_valid32;
      @(negedge clk);
      checks++;
      if (ve !== 1'b0 || out_valid32 !== 1'b1)
        begin fails++; $display("FAIL fp32[%0d] latency: early=%b valid=%b required 0/1", i, ve, out_valid32); end
      checks++;
      if (result32 !== vr[i]) begin fails++; $display("FAIL fp32[%0d] result: got %h required %h", i, result32, vr[i]); end
      checks++;
      if ({overflow32, zero32, nan32, inexact32} !== vf[i])
        begin fails++; $display("FAIL fp32[%0d] flags: got %b required %b", i, {overflow32, zero32, nan32, inexact32}, vf[i]); end
    end
  endtask

  initial begin
    in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
    test_reset();
    test_add();
    test_zero();
    test_round();
    test_special();
    test_backpressure();
    test_reset_midflight();
    test_fp32();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
